// File: rtl/hazard_ctrl_if.sv
// Pipeline-status / pipeline-control bundle between the datapath and hazard_ctrl.
// master = datapath side (drives hazard sources), slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        use_rs_id;
  logic        use_rt_id;
  logic        md_use_id;
  logic        memread_ex;
  logic [4:0]  rd_ex;
  logic        branch_taken_ex;
  logic        md_start_ex;
  logic        dmem_req_mem;
  logic        dmem_ready_mem;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_flush;
  logic        md_busy;
  logic        md_done;
  logic        mem_err;
  logic [31:0] stall_cnt;

  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id, md_use_id,
           memread_ex, rd_ex, branch_taken_ex, md_start_ex,
           dmem_req_mem, dmem_ready_mem,
    input  pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, memwb_flush,
           md_busy, md_done, mem_err, stall_cnt
  );

  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id, md_use_id,
           memread_ex, rd_ex, branch_taken_ex, md_start_ex,
           dmem_req_mem, dmem_ready_mem,
    output pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, memwb_flush,
           md_busy, md_done, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing controller: load-use, taken-branch, data-memory
// wait and MD-occupancy resolution, plus memory-timeout flag and stall counter.
module hazard_ctrl #(
  parameter int unsigned MD_LAT      = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave bus
);

  logic [7:0]  md_cnt_q,    md_cnt_d;
  logic [15:0] wcnt_q,      wcnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        mem_err_q,   mem_err_d;

  logic mem_stall;
  logic load_use;
  logic md_stall;
  logic md_accept;
  logic md_busy;
  logic pc_en, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_flush, memwb_flush;

  always_comb begin
    mem_stall = bus.dmem_req_mem & ~bus.dmem_ready_mem;
    load_use  = bus.memread_ex & (bus.rd_ex != 5'd0) &
                ((bus.use_rs_id & (bus.rs_id == bus.rd_ex)) |
                 (bus.use_rt_id & (bus.rt_id == bus.rd_ex)));
    md_busy   = (md_cnt_q != 8'd0);
    md_stall  = md_busy & bus.md_use_id;
    md_accept = bus.md_start_ex & ~mem_stall;
  end

  // Single prioritised action per cycle; reset forces every control low.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (bus.branch_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (md_stall | load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_accept)
      md_cnt_d = 8'(MD_LAT);
    else if (md_busy)
      md_cnt_d = md_cnt_q - 8'd1;

    wcnt_d    = mem_stall ? (wcnt_q + 16'd1) : '0;
    mem_err_d = mem_err_q | (mem_stall & (wcnt_q == 16'(MEM_TIMEOUT - 1)));

    stall_cnt_d = stall_cnt_q + {31'd0, ~pc_en};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt_q    <= '0;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.md_busy     = md_busy;
  assign bus.md_done     = (md_cnt_q == 8'd1) & ~md_accept;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MD_LAT=3, MEM_TIMEOUT=4.
module tb_hazard_ctrl;
  localparam int unsigned LAT = 3;
  localparam int unsigned TO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MD_LAT(LAT), .MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
  logic [6:0] dut_ctl;
  assign dut_ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                    bus.ifid_flush, bus.idex_flush, bus.memwb_flush};

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_md_cnt = 0;
  int unsigned m_wcnt   = 0;
  logic        m_err    = 1'b0;
  logic [31:0] m_scnt   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rs_id = '0; bus.rt_id = '0; bus.use_rs_id = 0; bus.use_rt_id = 0;
    bus.md_use_id = 0; bus.memread_ex = 0; bus.rd_ex = '0;
    bus.branch_taken_ex = 0; bus.md_start_ex = 0;
    bus.dmem_req_mem = 0; bus.dmem_ready_mem = 0;
  endtask

  task automatic step(input string tag);
    exp_t e;
    logic ms, lu, mds;
    ms  = bus.dmem_req_mem && !bus.dmem_ready_mem;
    lu  = bus.memread_ex && bus.rd_ex != 0 &&
          ((bus.use_rs_id && bus.rs_id == bus.rd_ex) ||
           (bus.use_rt_id && bus.rt_id == bus.rd_ex));
    mds = (m_md_cnt > 0) && bus.md_use_id;
    e.tag = tag;
    if (ms)                   e.ctl = 7'b0000_001;
    else if (bus.branch_taken_ex) e.ctl = 7'b1111_110;
    else if (mds || lu)       e.ctl = 7'b0011_010;
    else                      e.ctl = 7'b1111_000;
    e.busy = (m_md_cnt > 0);
    e.done = (m_md_cnt == 1) && !(bus.md_start_ex && !ms);
    e.err  = m_err;
    e.scnt = m_scnt;
    exp_q.push_back(e);

    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_q"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_ctl"},  {25'd0, dut_ctl},     {25'd0, e.ctl});
      check({e.tag, "_busy"}, {31'd0, bus.md_busy}, {31'd0, e.busy});
      check({e.tag, "_done"}, {31'd0, bus.md_done}, {31'd0, e.done});
      check({e.tag, "_err"},  {31'd0, bus.mem_err}, {31'd0, e.err});
      check({e.tag, "_scnt"}, bus.stall_cnt,        e.scnt);
    end

    @(posedge clk);
    if (e.ctl[6] == 1'b0) m_scnt = m_scnt + 1;
    if (ms) begin
      if (m_wcnt == TO - 1) m_err = 1'b1;
      m_wcnt++;
    end else begin
      m_wcnt = 0;
    end
    if (bus.md_start_ex && !ms) m_md_cnt = LAT;
    else if (m_md_cnt > 0)      m_md_cnt--;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl",  {25'd0, dut_ctl}, 32'd0);
    check("rst_busy", {31'd0, bus.md_busy}, 32'd0);
    check("rst_scnt", bus.stall_cnt, 32'd0);
    rst = 1'b0;

    step("idle");

    // Load-use on rs, then clears the next cycle
    bus.memread_ex = 1; bus.rd_ex = 5; bus.use_rs_id = 1; bus.rs_id = 5;
    step("lu_rs");
    clear_inputs();
    step("lu_after");
    check("lu_scnt", bus.stall_cnt, 32'd1);

    bus.memread_ex = 1; bus.rd_ex = 0; bus.use_rs_id = 1; bus.rs_id = 0;
    step("lu_r0");
    clear_inputs();
    bus.memread_ex = 1; bus.rd_ex = 7; bus.use_rt_id = 1; bus.rt_id = 7; bus.rs_id = 3;
    step("lu_rt");
    clear_inputs();

    bus.branch_taken_ex = 1;
    step("br");
    bus.memread_ex = 1; bus.rd_ex = 9; bus.use_rs_id = 1; bus.rs_id = 9;
    step("br_lu");
    clear_inputs();
    step("br_after");
    check("br_scnt", bus.stall_cnt, 32'd2);

    // Memory wait of 3 cycles, branch ignored during the wait
    bus.dmem_req_mem = 1; bus.dmem_ready_mem = 0;
    step("mw1");
    bus.branch_taken_ex = 1;
    step("mw2_br");
    bus.branch_taken_ex = 0;
    step("mw3");
    bus.dmem_ready_mem = 1;
    step("mw_rdy");
    clear_inputs();
    step("mw_after");
    check("mw_scnt", bus.stall_cnt, 32'd5);

    // MD sequencing with a dependent instruction waiting in ID
    bus.md_start_ex = 1;
    step("md_start");
    bus.md_start_ex = 0; bus.md_use_id = 1;
    for (int i = 0; i < 4; i++) step($sformatf("md_use%0d", i));
    clear_inputs();

    // Restart when md_cnt==1 reloads and suppresses md_done
    bus.md_start_ex = 1;
    step("rs_start");
    bus.md_start_ex = 0;
    step("rs_c3");
    step("rs_c2");
    bus.md_start_ex = 1;
    step("rs_c1_restart");
    bus.md_start_ex = 0;
    for (int i = 0; i < 4; i++) step($sformatf("rs_drain%0d", i));

    // Start during a memory wait is not accepted
    bus.md_start_ex = 1; bus.dmem_req_mem = 1; bus.dmem_ready_mem = 0;
    step("md_in_mw");
    clear_inputs();
    step("md_in_mw_after");

    // Timeout: ready low for 6 cycles with MEM_TIMEOUT=4
    bus.dmem_req_mem = 1; bus.dmem_ready_mem = 0;
    for (int i = 0; i < 6; i++) step($sformatf("to%0d", i));
    bus.dmem_ready_mem = 1;
    step("to_rdy");
    clear_inputs();
    step("to_after");
    check("to_sticky", {31'd0, bus.mem_err}, 32'd1);

    // Asynchronous reset mid-MD with mem_err set
    bus.md_start_ex = 1;
    step("ar_start");
    bus.md_start_ex = 0;
    step("ar_c3");
    bus.md_use_id = 1;
    rst = 1'b1;
    #1;
    check("ar_ctl",  {25'd0, dut_ctl}, 32'd0);
    check("ar_busy", {31'd0, bus.md_busy}, 32'd0);
    check("ar_done", {31'd0, bus.md_done}, 32'd0);
    check("ar_err",  {31'd0, bus.mem_err}, 32'd0);
    check("ar_scnt", bus.stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_md_cnt = 0; m_wcnt = 0; m_err = 1'b0; m_scnt = '0;
    step("ar_release");
    clear_inputs();
    step("ar_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage processor. It drives the hold (enable) and bubble (flush) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions: load-use hazards, taken branches, multi-cycle data-memory waits and multi-cycle MD (mult/div) occupancy. It also tracks memory-wait timeouts and counts stall cycles for performance monitoring.

## Interface
- MD_LAT, 8: MD unit latency in cycles (2..255).
- MEM_TIMEOUT, 255: consecutive memory-wait cycles that raise mem_err (1..65535).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_id, rt_id  in  5 each  source register numbers of the instruction in ID.
- use_rs_id, use_rt_id  in  1 each  ID instruction reads rs / rt.
- md_use_id  in  1  ID instruction reads HI/LO (mfhi/mflo/mult/div).
- memread_ex  in  1  EX instruction is a load.
- rd_ex  in  5  destination register of the EX instruction.
- branch_taken_ex  in  1  branch/jump in EX redirects the PC.
- md_start_ex  in  1  EX instruction starts the MD unit.
- dmem_req_mem, dmem_ready_mem  in  1 each  data-memory request and ready, MEM stage.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables (1 = advance).
- ifid_flush, idex_flush, memwb_flush  out  1 each  load zeros (bubble) on the next edge.
- md_busy  out  1  MD unit occupied.
- md_done  out  1  one-cycle pulse on MD completion.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  32  count of cycles with pc_en=0.

## Operation
- Defaults: all enables are 1 and all flushes are 0.
- Decoded conditions (combinational):
  - mem_stall = dmem_req_mem & ~dmem_ready_mem.
  - load_use = memread_ex & rd_ex≠0 & ((use_rs_id & rs_id==rd_ex) | (use_rt_id & rt_id==rd_ex)).
  - md_stall = md_busy & md_use_id.
- Priority, highest first; exactly one action applies per cycle:
  1. mem_stall: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_flush is 1. branch_taken_ex is ignored this cycle. EX is held, so the branch re-presents after the wait.
  2. branch_taken_ex: ifid_flush and idex_flush are 1; all enables are 1, so the PC loads the target.
  3. md_stall or load_use: pc_en and ifid_en are 0; idex_flush is 1; EX/MEM and MEM/WB advance.
- MD counter md_cnt (8-bit):
  - On md_start_ex & ~mem_stall, load MD_LAT. This takes precedence over decrement, so a restart while busy reloads the counter.
  - Otherwise, if md_cnt≠0, decrement every cycle, including during mem_stall.
  - md_busy = (md_cnt≠0). md_done is 1 on the cycle md_cnt==1 and no restart is occurring.
- Memory-wait counter wcnt (16-bit):
  - Increments on each mem_stall cycle and clears to 0 on any cycle without mem_stall.
  - When wcnt reaches MEM_TIMEOUT-1 while mem_stall is still asserted, mem_err sets on that edge. mem_err stays set until rst; the stall itself continues.
- stall_cnt increments on every cycle with pc_en=0 and wraps 2^32-1 → 0.

## Timing
- Enables and flushes are purely combinational from the current inputs and md_cnt. There is no added latency: they act on the same edge.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and the condition clears.
- A memory wait lasts as long as ready is low. On the first cycle ready=1, the pipeline advances on that edge.
- md_busy rises the cycle after the accepting edge and stays high for MD_LAT cycles. An md_use_id instruction stalls until the cycle after md_done.
- Reset:
  - While rst=1, all enables and flushes are 0.
  - md_cnt, wcnt, stall_cnt, mem_err, md_busy and md_done are 0.
  - Asserting rst mid-stall or mid-MD aborts immediately. After deassertion the controller starts clean, and the first edge performs normal advance.
- Simultaneous events:
  - mem_stall + branch: the stall wins.
  - branch + load_use: the flush wins and no extra stall occurs.
  - md_stall + load_use: a single 1-cycle bubble.

## Test plan
- Load-use hazard:
  - Stimulus: memread_ex=1, rd_ex=5, use_rs_id=1, rs_id=5.
  - Response: pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; stall_cnt=1.
  - Repeat with rd_ex=0: no stall.
- Taken branch:
  - Stimulus: branch_taken_ex=1.
  - Response: ifid_flush=idex_flush=1, all enables=1.
  - Same cycle with load_use also true: no stall, stall_cnt unchanged.
- Memory wait:
  - Stimulus: dmem_req_mem=1, ready low 3 cycles then high.
  - Response: pc/ifid/idex/exmem enables=0 and memwb_flush=1 for 3 cycles; advance on the 4th; stall_cnt=3.
- Memory timeout:
  - Stimulus: MEM_TIMEOUT=4, ready held low 6 cycles.
  - Response: mem_err rises after the 4th stall edge and remains 1 after ready returns, until rst.
- MD sequencing:
  - Stimulus: MD_LAT=3; md_start_ex pulse; then md_use_id=1.
  - Response: md_busy high 3 cycles, md_done on the 3rd, ID stalled 3 cycles.
  - Restart: md_start_ex while md_cnt=1 reloads 3 and suppresses md_done.
- Asynchronous reset:
  - Stimulus: assert rst mid-MD (md_cnt=2) with mem_err=1.
  - Response: all outputs go to 0 without waiting for a clock edge.
  - After release: normal advance, md_busy=0.
